// File: rtl/alu_uart_pkg.sv
// Shared definitions for the ALU-UART design: default widths, the opcode
// set understood by the ALU, and the sequencer state encoding.
package alu_uart_pkg;

  localparam int unsigned N_BITS_DEFAULT = 8;
  localparam int unsigned N_OP_DEFAULT   = 6;

  localparam logic [N_OP_DEFAULT-1:0] OP_ADD = 6'b100000;
  localparam logic [N_OP_DEFAULT-1:0] OP_SUB = 6'b100010;
  localparam logic [N_OP_DEFAULT-1:0] OP_AND = 6'b100100;
  localparam logic [N_OP_DEFAULT-1:0] OP_OR  = 6'b100101;
  localparam logic [N_OP_DEFAULT-1:0] OP_XOR = 6'b100110;
  localparam logic [N_OP_DEFAULT-1:0] OP_NOR = 6'b100111;
  localparam logic [N_OP_DEFAULT-1:0] OP_SRA = 6'b000011;
  localparam logic [N_OP_DEFAULT-1:0] OP_SRL = 6'b000010;

  typedef enum logic [2:0] {
    WAIT_A,
    WAIT_B,
    WAIT_OP,
    EXEC,
    SEND,
    WAIT_TX
  } state_t;

  function automatic logic is_valid_op(input logic [N_OP_DEFAULT-1:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR,
      OP_XOR, OP_NOR, OP_SRA, OP_SRL: return 1'b1;
      default:                        return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/frame_timeout_counter.sv
// Inter-byte timeout counter for the uart frame sequencer.
// Ports:
//   i_clock, i_reset (async, active-low)
//   i_clear  : restart the count (byte received)
//   i_enable : count while a frame is partially received; held at 0 otherwise
//   o_expire : high for the cycle in which the count sits at TIMEOUT-1
//              while enabled and not being cleared
module frame_timeout_counter #(
  parameter int unsigned TIMEOUT    = 2500000,
  parameter int unsigned NB_TIMEOUT = 22
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expire
);

  localparam logic [NB_TIMEOUT-1:0] LAST = NB_TIMEOUT'(TIMEOUT - 1);

  logic [NB_TIMEOUT-1:0] count;

  // Clearing whenever disabled gives a fresh count on every entry into a
  // counting state without the counter needing to see the state itself.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      count <= '0;
    end else if (i_clear || !i_enable) begin
      count <= '0;
    end else if (count != LAST) begin
      count <= count + NB_TIMEOUT'(1);
    end
  end

  assign o_expire = i_enable && !i_clear && (count == LAST);

endmodule

// File: rtl/uart_alu_interface.sv
// Sequencer between the uart rx/tx and the combinational ALU.
// Collects operand A, operand B and opcode bytes, presents them to the ALU,
// registers the result and starts a uart transmission.
// Ports:
//   i_clock, i_reset (async, active-low)
//   i_rx_done_tick / i_rx_data : received byte strobe and data
//   i_tx_done_tick             : uart transmission finished
//   i_alu_result               : combinational ALU output
//   o_alu_a / o_alu_b / o_alu_op : registered ALU inputs
//   o_tx_start / o_tx_data     : transmit strobe (one cycle) and byte
//   o_busy                     : result in flight (EXEC .. WAIT_TX)
//   o_op_error, o_timeout, o_overrun : one-cycle event pulses
module uart_alu_interface
  import alu_uart_pkg::*;
#(
  parameter int unsigned N_BITS     = N_BITS_DEFAULT,
  parameter int unsigned N_OP       = N_OP_DEFAULT,
  parameter int unsigned TIMEOUT    = 2500000,
  parameter int unsigned NB_TIMEOUT = 22
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic              i_rx_done_tick,
  input  logic [N_BITS-1:0] i_rx_data,
  input  logic              i_tx_done_tick,
  input  logic [N_BITS-1:0] i_alu_result,
  output logic [N_BITS-1:0] o_alu_a,
  output logic [N_BITS-1:0] o_alu_b,
  output logic [N_OP-1:0]   o_alu_op,
  output logic              o_tx_start,
  output logic [N_BITS-1:0] o_tx_data,
  output logic              o_busy,
  output logic              o_op_error,
  output logic              o_timeout,
  output logic              o_overrun
);

  state_t          state;
  logic            frame_active;
  logic            timer_expire;
  logic [N_OP-1:0] rx_op;
  logic            rx_high_unused;

  assign frame_active = (state == WAIT_B) || (state == WAIT_OP);
  assign rx_op        = i_rx_data[N_OP-1:0];
  // Opcode byte bits above N_OP carry no meaning.
  assign rx_high_unused = ^i_rx_data[N_BITS-1:N_OP];

  frame_timeout_counter #(
    .TIMEOUT    (TIMEOUT),
    .NB_TIMEOUT (NB_TIMEOUT)
  ) u_frame_timeout (
    .i_clock  (i_clock),
    .i_reset  (i_reset),
    .i_clear  (i_rx_done_tick),
    .i_enable (frame_active),
    .o_expire (timer_expire)
  );

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state      <= WAIT_A;
      o_alu_a    <= '0;
      o_alu_b    <= '0;
      o_alu_op   <= '0;
      o_tx_data  <= '0;
      o_tx_start <= 1'b0;
      o_busy     <= 1'b0;
      o_op_error <= 1'b0;
      o_timeout  <= 1'b0;
      o_overrun  <= 1'b0;
    end else begin
      o_tx_start <= 1'b0;
      o_op_error <= 1'b0;
      o_timeout  <= 1'b0;
      o_overrun  <= 1'b0;

      // Bytes arriving while a result is in flight are dropped.
      if (i_rx_done_tick && (state == EXEC || state == SEND || state == WAIT_TX))
        o_overrun <= 1'b1;

      case (state)
        WAIT_A: begin
          if (i_rx_done_tick) begin
            o_alu_a <= i_rx_data;
            state   <= WAIT_B;
          end
        end
        WAIT_B: begin
          if (i_rx_done_tick) begin
            o_alu_b <= i_rx_data;
            state   <= WAIT_OP;
          end else if (timer_expire) begin
            o_timeout <= 1'b1;
            state     <= WAIT_A;
          end
        end
        WAIT_OP: begin
          if (i_rx_done_tick) begin
            if (is_valid_op(rx_op)) begin
              o_alu_op <= rx_op;
              o_busy   <= 1'b1;
              state    <= EXEC;
            end else begin
              o_op_error <= 1'b1;
              state      <= WAIT_A;
            end
          end else if (timer_expire) begin
            o_timeout <= 1'b1;
            state     <= WAIT_A;
          end
        end
        EXEC: begin
          // ALU inputs have been stable for a full cycle here.
          o_tx_data  <= i_alu_result;
          o_tx_start <= 1'b1;
          state      <= SEND;
        end
        SEND: begin
          state <= WAIT_TX;
        end
        WAIT_TX: begin
          if (i_tx_done_tick) begin
            o_busy <= 1'b0;
            state  <= WAIT_A;
          end
        end
        default: begin
          o_busy <= 1'b0;
          state  <= WAIT_A;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_alu_interface.sv
// Bench for uart_alu_interface with TIMEOUT=1000 and a reference ALU.
module tb_uart_alu_interface;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx_tick = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       tx_done = 1'b0;
  logic [7:0] alu_result;
  logic [7:0] alu_a, alu_b, tx_data;
  logic [5:0] alu_op;
  logic       tx_start, busy, op_error, timeout, overrun;

  uart_alu_interface #(
    .N_BITS     (8),
    .N_OP       (6),
    .TIMEOUT    (1000),
    .NB_TIMEOUT (10)
  ) dut (
    .i_clock        (clk),
    .i_reset        (rst_n),
    .i_rx_done_tick (rx_tick),
    .i_rx_data      (rx_data),
    .i_tx_done_tick (tx_done),
    .i_alu_result   (alu_result),
    .o_alu_a        (alu_a),
    .o_alu_b        (alu_b),
    .o_alu_op       (alu_op),
    .o_tx_start     (tx_start),
    .o_tx_data      (tx_data),
    .o_busy         (busy),
    .o_op_error     (op_error),
    .o_timeout      (timeout),
    .o_overrun      (overrun)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] ref_alu(input logic [7:0] a, input logic [7:0] b,
                                         input logic [5:0] op);
    case (op)
      6'b100000: return a + b;
      6'b100010: return a - b;
      6'b100100: return a & b;
      6'b100101: return a | b;
      6'b100110: return a ^ b;
      6'b100111: return ~(a | b);
      6'b000011: return 8'($signed(a) >>> b);
      6'b000010: return a >> b;
      default:   return 8'h00;
    endcase
  endfunction

  assign alu_result = ref_alu(alu_a, alu_b, alu_op);

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    logic [7:0] data;
    int         at;
  } exp_t;
  exp_t sb[$];

  int tests = 0;
  int fails = 0;
  int n_start = 0, n_err = 0, n_to = 0, n_ovr = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard side: every o_tx_start pops one expected byte and its cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      if (tx_start) begin
        n_start++;
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_tx_start: got tx_data %0h with no frame pending", tx_data);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("tx_data", {24'h0, tx_data}, {24'h0, e.data});
          check("tx_start_cycle", cyc, e.at);
        end
      end
      if (op_error) n_err++;
      if (timeout)  n_to++;
      if (overrun)  n_ovr++;
    end
  end

  task automatic send_byte(input logic [7:0] b, input logic expect_tx, input logic [7:0] exp);
    @(negedge clk);
    rx_data = b;
    rx_tick = 1'b1;
    if (expect_tx) sb.push_back('{data: exp, at: cyc + 2});
    @(negedge clk);
    rx_tick = 1'b0;
  endtask

  task automatic wait_start(input string name);
    int k;
    k = 0;
    while (sb.size() != 0 && k < 10) begin
      @(negedge clk);
      #1;
      k++;
    end
    check({"start_seen_", name}, sb.size(), 0);
    sb.delete();
  endtask

  task automatic tx_complete(input string name);
    @(negedge clk);
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
    check({"busy_after_done_", name}, {31'h0, busy}, 0);
  endtask

  task automatic run_frame(input string name, input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] op, input logic valid, input logic [7:0] exp);
    int s0, e0;
    logic [5:0] op_before;
    s0 = n_start;
    e0 = n_err;
    op_before = alu_op;
    send_byte(a, 1'b0, 8'h00);
    send_byte(b, 1'b0, 8'h00);
    send_byte(op, valid, exp);
    check({"alu_a_", name}, {24'h0, alu_a}, {24'h0, a});
    check({"alu_b_", name}, {24'h0, alu_b}, {24'h0, b});
    if (valid) begin
      check({"alu_op_", name}, {26'h0, alu_op}, {26'h0, op[5:0]});
      check({"busy_", name}, {31'h0, busy}, 1);
      wait_start(name);
      tx_complete(name);
      check({"one_start_", name}, n_start - s0, 1);
    end else begin
      repeat (5) @(negedge clk);
      #1;
      check({"op_error_once_", name}, n_err - e0, 1);
      check({"no_start_", name}, n_start - s0, 0);
      check({"alu_op_kept_", name}, {26'h0, alu_op}, {26'h0, op_before});
      check({"not_busy_", name}, {31'h0, busy}, 0);
    end
  endtask

  typedef struct {
    string      name;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] op;
    logic       valid;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[13];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d tests so far", tests);
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, s0, o0;

    vecs[0]  = '{"add",        8'h05, 8'h03, 8'h20, 1'b1, 8'h08};
    vecs[1]  = '{"xor",        8'h0F, 8'h3C, 8'h26, 1'b1, 8'h33};
    vecs[2]  = '{"sub_zero",   8'h01, 8'h01, 8'h22, 1'b1, 8'h00};
    vecs[3]  = '{"invalid_3f", 8'h01, 8'h02, 8'h3F, 1'b0, 8'h00};
    vecs[4]  = '{"add_after",  8'h02, 8'h02, 8'h20, 1'b1, 8'h04};
    vecs[5]  = '{"and",        8'hF0, 8'h3C, 8'h24, 1'b1, 8'h30};
    vecs[6]  = '{"or",         8'h0F, 8'h30, 8'h25, 1'b1, 8'h3F};
    vecs[7]  = '{"nor",        8'h0F, 8'h30, 8'h27, 1'b1, 8'hC0};
    vecs[8]  = '{"sra",        8'h80, 8'h01, 8'h03, 1'b1, 8'hC0};
    vecs[9]  = '{"srl",        8'h80, 8'h01, 8'h02, 1'b1, 8'h40};
    vecs[10] = '{"high_bits",  8'h05, 8'h03, 8'hE0, 1'b1, 8'h08};
    vecs[11] = '{"sub_wrap",   8'h03, 8'h05, 8'h22, 1'b1, 8'hFE};
    vecs[12] = '{"invalid_c1", 8'h01, 8'h02, 8'hC1, 1'b0, 8'h00};

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_alu_a", {24'h0, alu_a}, 0);
    check("rst_alu_b", {24'h0, alu_b}, 0);
    check("rst_alu_op", {26'h0, alu_op}, 0);
    check("rst_tx_data", {24'h0, tx_data}, 0);
    check("rst_pulses", {27'h0, tx_start, busy, op_error, timeout, overrun}, 0);
    rst_n = 1'b1;

    foreach (vecs[i]) run_frame(vecs[i].name, vecs[i].a, vecs[i].b, vecs[i].op,
                                vecs[i].valid, vecs[i].exp);

    // Timeout after operand A: pulse in the 1000th cycle after capture
    t0 = n_to;
    s0 = n_start;
    send_byte(8'h07, 1'b0, 8'h00);
    repeat (999) @(negedge clk);
    check("timeout_not_early", {31'h0, timeout}, 0);
    @(negedge clk);
    check("timeout_pulse", {31'h0, timeout}, 1);
    repeat (20) @(negedge clk);
    #1;
    check("timeout_once", n_to - t0, 1);
    check("timeout_no_start", n_start - s0, 0);
    run_frame("after_timeout", 8'h01, 8'h01, 8'h20, 1'b1, 8'h02);

    // Tick on the expiry cycle wins over the timeout
    t0 = n_to;
    send_byte(8'h07, 1'b0, 8'h00);
    repeat (998) @(negedge clk);
    send_byte(8'h09, 1'b0, 8'h00);
    send_byte(8'h20, 1'b1, 8'h10);
    #1;
    check("tie_alu_a", {24'h0, alu_a}, 32'h07);
    check("tie_alu_b", {24'h0, alu_b}, 32'h09);
    wait_start("tie");
    tx_complete("tie");
    check("tie_no_timeout", n_to - t0, 0);

    // Overrun during WAIT_TX
    send_byte(8'h10, 1'b0, 8'h00);
    send_byte(8'h20, 1'b0, 8'h00);
    send_byte(8'h20, 1'b1, 8'h30);
    wait_start("pre_overrun");
    o0 = n_ovr;
    send_byte(8'hAA, 1'b0, 8'h00);
    #1;
    check("overrun_once", n_ovr - o0, 1);
    check("overrun_tx_data_held", {24'h0, tx_data}, 32'h30);
    check("overrun_still_busy", {31'h0, busy}, 1);
    check("overrun_alu_a_kept", {24'h0, alu_a}, 32'h10);
    tx_complete("overrun");
    run_frame("srl_after_overrun", 8'h04, 8'h01, 8'h02, 1'b1, 8'h02);

    // Asynchronous reset in WAIT_OP
    send_byte(8'h11, 1'b0, 8'h00);
    send_byte(8'h22, 1'b0, 8'h00);
    #2 rst_n = 1'b0;
    #1;
    check("rst_op_alu_a", {24'h0, alu_a}, 0);
    check("rst_op_alu_b", {24'h0, alu_b}, 0);
    check("rst_op_alu_op", {26'h0, alu_op}, 0);
    check("rst_op_tx_data", {24'h0, tx_data}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Asynchronous reset in WAIT_TX
    send_byte(8'h10, 1'b0, 8'h00);
    send_byte(8'h20, 1'b0, 8'h00);
    send_byte(8'h20, 1'b1, 8'h30);
    wait_start("pre_reset_tx");
    #1 rst_n = 1'b0;
    #1;
    check("rst_tx_busy", {31'h0, busy}, 0);
    check("rst_tx_tx_data", {24'h0, tx_data}, 0);
    check("rst_tx_alu_a", {24'h0, alu_a}, 0);
    check("rst_tx_alu_op", {26'h0, alu_op}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_frame("after_reset", 8'h02, 8'h02, 8'h20, 1'b1, 8'h04);

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_alu_interface.md
Name: uart_alu_interface

Overview:
- Sequencer between the uart block (rx/tx) and the combinational ALU on the Basys3 ALU-UART design.
- Collects three received bytes in order: operand A, operand B, opcode. Drives them to the ALU, registers the ALU result, and hands it to the uart transmitter with a start pulse.
- A frame-timeout counter resynchronises the byte sequence if the host stalls mid-frame.

Parameters:
- N_BITS, 8: data/operand/result width; matches uart N_BITS.
- N_OP, 6: opcode width; the low N_OP bits of the third byte.
- TIMEOUT, 2500000: clock cycles allowed between bytes of one frame (50 ms at 50 MHz).
- NB_TIMEOUT, 22: timeout counter width; must satisfy 2^NB_TIMEOUT > TIMEOUT.

Ports:
- i_clock  in  1  system clock, 50 MHz.
- i_reset  in  1  asynchronous, active-low reset.
- i_rx_done_tick  in  1  one-cycle pulse from uart: i_rx_data is valid.
- i_rx_data  in  N_BITS  received byte (uart o_dout).
- i_tx_done_tick  in  1  one-cycle pulse from uart: transmission finished.
- i_alu_result  in  N_BITS  combinational ALU result.
- o_alu_a  out  N_BITS  registered operand A.
- o_alu_b  out  N_BITS  registered operand B.
- o_alu_op  out  N_OP  registered opcode.
- o_tx_start  out  1  one-cycle pulse to uart i_ready.
- o_tx_data  out  N_BITS  byte to transmit (uart i_din).
- o_busy  out  1  high from opcode capture until i_tx_done_tick.
- o_op_error  out  1  one-cycle pulse: invalid opcode received.
- o_timeout  out  1  one-cycle pulse: frame aborted by timeout.
- o_overrun  out  1  one-cycle pulse: byte received while busy and dropped.

Behaviour:
- Reset (i_reset low, asynchronous):
  - State goes to WAIT_A.
  - o_alu_a, o_alu_b, o_alu_op, o_tx_data are 0.
  - All pulse outputs and o_busy are 0.
  - Timeout counter is 0.
- A reset mid-frame or mid-transmit discards everything; the uart is not signalled.
- States: WAIT_A, WAIT_B, WAIT_OP, EXEC, SEND, WAIT_TX.
- WAIT_A: on i_rx_done_tick, o_alu_a <= i_rx_data, go to WAIT_B. No timeout is active in this state.
- WAIT_B: on i_rx_done_tick, o_alu_b <= i_rx_data, go to WAIT_OP.
- WAIT_OP: on i_rx_done_tick:
  - If i_rx_data[N_OP-1:0] is a valid opcode: latch it to o_alu_op, go to EXEC.
  - Otherwise: pulse o_op_error, go to WAIT_A. Operands are kept, o_alu_op is unchanged, nothing is transmitted.
  - Bits above N_OP are ignored.
- EXEC: one cycle so the ALU settles on the new registers; o_tx_data <= i_alu_result; go to SEND.
- SEND: o_tx_start = 1 for exactly this cycle; go to WAIT_TX.
- WAIT_TX: hold o_tx_data stable; on i_tx_done_tick go to WAIT_A.
- o_busy = 1 in EXEC, SEND and WAIT_TX.
- Latency: o_tx_start asserts 2 cycles after the opcode i_rx_done_tick.
- Timeout:
  - Counter clears on every i_rx_done_tick and on every state entry.
  - It increments each cycle in WAIT_B and WAIT_OP.
  - When it reaches TIMEOUT-1 with no tick: pulse o_timeout, go to WAIT_A.
  - If a tick and the timeout occur in the same cycle, the tick wins: the byte is captured and there is no timeout pulse.
- Overrun: i_rx_done_tick in EXEC, SEND or WAIT_TX pulses o_overrun. The byte is dropped and the state is unchanged.
- i_tx_done_tick outside WAIT_TX is ignored.
- Back-to-back frames: a tick in the same cycle as the WAIT_TX→WAIT_A transition is an overrun. The host must wait for the result byte.
- Valid opcodes:
  - ADD 100000, SUB 100010, AND 100100, OR 100101
  - XOR 100110, NOR 100111, SRA 000011, SRL 000010

Decomposition:
- Shared package alu_uart_pkg:
  - Opcode localparams (OP_ADD…OP_SRL).
  - N_BITS and N_OP defaults.
  - State encoding.
- The ALU reads the same opcode constants from this package.
- One sub-module: frame_timeout_counter, parameterised by TIMEOUT and NB_TIMEOUT.
  - Inputs: clear, enable.
  - Output: one-cycle expire pulse.

Test Plan (bench with TIMEOUT=1000; rx/tx ticks driven directly as one-cycle pulses):
- Bytes 0x05, 0x03, 0x20 → o_alu_a=0x05, o_alu_b=0x03, o_alu_op=6'b100000. With a reference ALU, o_tx_data=0x08 and o_tx_start pulses exactly 2 cycles after the third tick. After i_tx_done_tick: o_busy falls, state is WAIT_A.
- Bytes 0x0F, 0x3C, 0x26 (XOR) → o_tx_data=0x33. A second frame 0x01, 0x01, 0x22 (SUB) then gives o_tx_data=0x00.
- Bytes 0x01, 0x02, 0x3F (invalid) → o_op_error pulses once, no o_tx_start. A following frame 0x02, 0x02, 0x20 transmits 0x04.
- Byte 0x07, then 1000 idle cycles → o_timeout pulses once, no further output. Next frame 0x01, 0x01, 0x20 transmits 0x02.
- A tick arriving on the cycle the timeout expires → byte captured, no o_timeout.
- Extra byte 0xAA sent during WAIT_TX → o_overrun pulses, o_tx_data unchanged. After tx done, frame 0x04, 0x01, 0x02 (SRL) transmits 0x02.
- Reset asserted in WAIT_OP and in WAIT_TX → all outputs 0 immediately, with no clock edge needed.
